alu_issue_ctrl: RTL and testbench

- Requester side of the ALU interface: accepts one decoded-from-raw RISC-V instruction plus register operands per valid/ready handshake.
- Derives ALUControl and the operand pair, drives the combinational ALU, captures ALUResult/zero one cycle later, and returns a registered result with branch decision.
- Sits between the register-read stage and writeback/PC-select logic.

---
 rtl/alu_issue_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// Requester side of the ALU: decodes an RV32 instruction into ALUControl and an
// operand pair, drives the external combinational ALU, and returns a registered result.
//
// state | meaning
// IDLE  | ready for a new instruction; operands/ctrl captured on handshake
// EXEC  | ALU evaluating issued operands; result/zero captured at end of cycle
// DONE  | result presented with out_valid until the consumer accepts it
module alu_issue_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    input  logic [WIDTH-1:0] rs1_val,
    input  logic [WIDTH-1:0] rs2_val,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_ctrl,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             branch_taken,
    output logic             illegal
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] CTRL_ADD = 3'b000;
    localparam logic [2:0] CTRL_SUB = 3'b001;
    localparam logic [2:0] CTRL_AND = 3'b010;
    localparam logic [2:0] CTRL_OR  = 3'b011;
    localparam logic [2:0] CTRL_SLT = 3'b100;
    localparam logic [2:0] CTRL_CMP = 3'b101;
    localparam logic [2:0] CTRL_ILL = 3'b111;

    state_t           state_q;
    logic [WIDTH-1:0] alu_a_q;
    logic [WIDTH-1:0] alu_b_q;
    logic [2:0]       alu_ctrl_q;
    logic [WIDTH-1:0] result_q;
    logic             out_valid_q;
    logic             branch_taken_q;
    logic             illegal_q;
    logic             is_beq_q;
    logic             is_bne_q;
    logic             is_ill_q;

    logic [WIDTH-1:0] imm_i;
    logic [WIDTH-1:0] imm_s;
    logic [2:0]       ctrl_d;
    logic [WIDTH-1:0] alu_b_d;
    logic             is_beq_d;
    logic             is_bne_d;
    logic             is_ill_d;
    logic [2:0]       funct3;
    logic             unused_instr;

    assign funct3       = instr[14:12];
    assign unused_instr = ^instr[19:15];
    assign imm_i        = {{(WIDTH-11){instr[31]}}, instr[30:20]};
    assign imm_s        = {{(WIDTH-11){instr[31]}}, instr[30:25], instr[11:7]};

    always_comb begin
        ctrl_d   = CTRL_ILL;
        alu_b_d  = rs2_val;
        is_beq_d = 1'b0;
        is_bne_d = 1'b0;
        unique case (instr[6:0])
            OP_R: begin
                unique case (funct3)
                    3'b000:  ctrl_d = instr[30] ? CTRL_SUB : CTRL_ADD;
                    3'b111:  ctrl_d = CTRL_AND;
                    3'b110:  ctrl_d = CTRL_OR;
                    3'b010:  ctrl_d = CTRL_SLT;
                    default: ctrl_d = CTRL_ILL;
                endcase
            end
            OP_I: begin
                alu_b_d = imm_i;
                unique case (funct3)
                    3'b000:  ctrl_d = CTRL_ADD;
                    3'b111:  ctrl_d = CTRL_AND;
                    3'b110:  ctrl_d = CTRL_OR;
                    3'b010:  ctrl_d = CTRL_SLT;
                    default: ctrl_d = CTRL_ILL;
                endcase
            end
            OP_LOAD: begin
                ctrl_d  = CTRL_ADD;
                alu_b_d = imm_i;
            end
            OP_STORE: begin
                ctrl_d  = CTRL_ADD;
                alu_b_d = imm_s;
            end
            OP_BRANCH: begin
                if (funct3 == 3'b000) begin
                    ctrl_d   = CTRL_CMP;
                    is_beq_d = 1'b1;
                end else if (funct3 == 3'b001) begin
                    ctrl_d   = CTRL_CMP;
                    is_bne_d = 1'b1;
                end
            end
            default: ctrl_d = CTRL_ILL;
        endcase
        is_ill_d = (ctrl_d == CTRL_ILL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            alu_a_q        <= '0;
            alu_b_q        <= '0;
            alu_ctrl_q     <= CTRL_ADD;
            result_q       <= '0;
            out_valid_q    <= 1'b0;
            branch_taken_q <= 1'b0;
            illegal_q      <= 1'b0;
            is_beq_q       <= 1'b0;
            is_bne_q       <= 1'b0;
            is_ill_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        alu_a_q    <= rs1_val;
                        alu_b_q    <= alu_b_d;
                        alu_ctrl_q <= ctrl_d;
                        is_beq_q   <= is_beq_d;
                        is_bne_q   <= is_bne_d;
                        is_ill_q   <= is_ill_d;
                        state_q    <= EXEC;
                    end
                end
                EXEC: begin
                    // Illegal ops still complete the handshake, but never leak ALU output.
                    result_q       <= is_ill_q ? '0 : alu_result;
                    branch_taken_q <= (is_beq_q & alu_zero) | (is_bne_q & ~alu_zero);
                    illegal_q      <= is_ill_q;
                    out_valid_q    <= 1'b1;
                    state_q        <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q    <= 1'b0;
                        branch_taken_q <= 1'b0;
                        illegal_q      <= 1'b0;
                        state_q        <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready     = (state_q == IDLE);
    assign alu_a        = alu_a_q;
    assign alu_b        = alu_b_q;
    assign alu_ctrl     = alu_ctrl_q;
    assign result       = result_q;
    assign out_valid    = out_valid_q;
    assign branch_taken = branch_taken_q;
    assign illegal      = illegal_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl: directed instructions, a behavioural ALU,
// and a monitor that checks every accepted result against a queue of expectations.
module tb_alu_issue_ctrl;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_ctrl;
    logic [31:0] alu_result;
    logic        alu_zero;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        branch_taken;
    logic        illegal;

    typedef struct packed {
        logic [31:0] res;
        logic        br;
        logic        ill;
        logic [2:0]  ctrl;
        logic [31:0] a;
        logic [31:0] b;
        logic        chk_b;
    } exp_t;

    exp_t q[$];
    int tests = 0;
    int fails = 0;

    alu_issue_ctrl #(.WIDTH(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .instr        (instr),
        .rs1_val      (rs1_val),
        .rs2_val      (rs2_val),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_ctrl     (alu_ctrl),
        .alu_result   (alu_result),
        .alu_zero     (alu_zero),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .result       (result),
        .branch_taken (branch_taken),
        .illegal      (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU; illegal ctrl returns a marker value so masking is visible.
    always_comb begin
        case (alu_ctrl)
            3'b000:  alu_result = alu_a + alu_b;
            3'b001:  alu_result = alu_a - alu_b;
            3'b010:  alu_result = alu_a & alu_b;
            3'b011:  alu_result = alu_a | alu_b;
            3'b100:  alu_result = {31'd0, $signed(alu_a) < $signed(alu_b)};
            3'b101:  alu_result = alu_a - alu_b;
            default: alu_result = 32'hDEADBEEF;
        endcase
        alu_zero = (alu_result == 32'd0);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (q.size() == 0) begin
                chk("unexpected_out_valid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("alu_ctrl", {29'd0, alu_ctrl}, {29'd0, e.ctrl});
                chk("alu_a", alu_a, e.a);
                if (e.chk_b) chk("alu_b", alu_b, e.b);
                chk("result", result, e.res);
                chk("branch_taken", {31'd0, branch_taken}, {31'd0, e.br});
                chk("illegal", {31'd0, illegal}, {31'd0, e.ill});
            end
        end
    end

    function automatic exp_t mk(input logic [31:0] res, input logic br, input logic ill,
                                input logic [2:0] ctrl, input logic [31:0] a,
                                input logic [31:0] b, input logic chk_b);
        exp_t e;
        e.res = res; e.br = br; e.ill = ill; e.ctrl = ctrl;
        e.a = a; e.b = b; e.chk_b = chk_b;
        return e;
    endfunction

    task automatic run_op(input logic [31:0] ins, input logic [31:0] r1,
                          input logic [31:0] r2, input exp_t e, input bit hold);
        int lat;
        logic [31:0] snap_res;
        logic        snap_br;
        @(posedge clk); #1;
        chk("in_ready_idle", {31'd0, in_ready}, 32'd1);
        instr = ins; rs1_val = r1; rs2_val = r2; in_valid = 1'b1;
        if (hold) out_ready = 1'b0;
        @(posedge clk);
        q.push_back(e);
        #1;
        in_valid = 1'b0;
        instr = 32'h0000_0033; rs1_val = 32'hA5A5_A5A5; rs2_val = 32'h5A5A_5A5A;
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("latency_edges", lat, 32'd2);
        if (hold) begin
            snap_res = result;
            snap_br  = branch_taken;
            in_valid = 1'b1;
            instr    = 32'h002081B3;
            for (int i = 0; i < 5; i++) begin
                @(posedge clk); #1;
                chk("hold_out_valid", {31'd0, out_valid}, 32'd1);
                chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
                chk("hold_result", result, snap_res);
                chk("hold_branch", {31'd0, branch_taken}, {31'd0, snap_br});
                chk("hold_alu_a", alu_a, e.a);
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
        end
        for (int n = 0; n < 10 && q.size() != 0; n++) begin
            @(negedge clk); #1;
        end
        if (q.size() != 0) begin
            chk("drain_timeout", q.size(), 32'd0);
            q.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        instr = 32'd0; rs1_val = 32'd0; rs2_val = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_alu_ctrl", {29'd0, alu_ctrl}, 32'd0);
        chk("rst_alu_a", alu_a, 32'd0);
        chk("rst_alu_b", alu_b, 32'd0);
        chk("rst_flags", {30'd0, branch_taken, illegal}, 32'd0);
        rst_n = 1'b1;

        run_op(32'h002081B3, 32'd5, 32'd7, mk(32'd12, 0, 0, 3'b000, 32'd5, 32'd7, 1), 0);
        run_op(32'h402081B3, 32'd10, 32'd3, mk(32'd7, 0, 0, 3'b001, 32'd10, 32'd3, 1), 0);
        run_op(32'hFFF08093, 32'd4, 32'd0, mk(32'd3, 0, 0, 3'b000, 32'd4, 32'hFFFFFFFF, 1), 0);
        run_op(32'h0020F1B3, 32'h0000F0F0, 32'h00000FF0,
               mk(32'h000000F0, 0, 0, 3'b010, 32'h0000F0F0, 32'h00000FF0, 1), 0);
        run_op(32'h0020E1B3, 32'h0000F0F0, 32'h00000FF0,
               mk(32'h0000FFF0, 0, 0, 3'b011, 32'h0000F0F0, 32'h00000FF0, 1), 0);
        run_op(32'h0020A1B3, 32'hFFFFFFFD, 32'd2,
               mk(32'd1, 0, 0, 3'b100, 32'hFFFFFFFD, 32'd2, 1), 0);
        run_op(32'h7FF0A183, 32'd1, 32'd0, mk(32'h800, 0, 0, 3'b000, 32'd1, 32'h7FF, 1), 0);
        run_op(32'hFE20AE23, 32'd100, 32'd55, mk(32'd96, 0, 0, 3'b000, 32'd100, 32'hFFFFFFFC, 1), 0);
        run_op(32'h00208463, 32'd9, 32'd9, mk(32'd0, 1, 0, 3'b101, 32'd9, 32'd9, 1), 0);
        run_op(32'h00209463, 32'd9, 32'd9, mk(32'd0, 0, 0, 3'b101, 32'd9, 32'd9, 1), 0);
        run_op(32'h00208463, 32'd9, 32'd8, mk(32'd1, 0, 0, 3'b101, 32'd9, 32'd8, 1), 0);
        run_op(32'h0000007F, 32'd6, 32'd2, mk(32'd0, 0, 1, 3'b111, 32'd6, 32'd0, 0), 0);
        run_op(32'h00209463, 32'd9, 32'd8, mk(32'd1, 1, 0, 3'b101, 32'd9, 32'd8, 1), 1);

        // Reset while the instruction is in EXEC: the transaction must vanish.
        @(posedge clk); #1;
        instr = 32'h002081B3; rs1_val = 32'd1; rs2_val = 32'd2; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst_n = 1'b0;
        q.delete();
        #1;
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("midrst_alu_a", alu_a, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            chk("postrst_out_valid", {31'd0, out_valid}, 32'd0);
        end
        chk("postrst_in_ready", {31'd0, in_ready}, 32'd1);

        run_op(32'h402081B3, 32'd20, 32'd25, mk(32'hFFFFFFFB, 0, 0, 3'b001, 32'd20, 32'd25, 1), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
